prom_burst_reader: RTL
======================

// Module: prom_burst_reader
// PURPOSE
//   Bus-master reader for the 27256-style 32Kx8 PROM (active-low CS/OE, byte-wide data).
//   Accepts a {start address, length} request and drives the PROM strobes with programmable access wait states.
//   Streams the fetched bytes out over a valid/ready byte stream.
//   Sits between the boot/config loader and the PROM model or pins.
// PARAMETERS
//   ADDR_W    15  PROM address width; addresses wrap modulo 2**ADDR_W
//   DATA_W    8   PROM data width
//   LEN_W     16  request length width in bytes (max burst 2**LEN_W-1)
//   WAIT_CYC  3   extra access cycles before sampling data (0..15; total access = WAIT_CYC+1 cycles)
// PORTS
//   clk          in   1       single clock
//   rst          in   1       synchronous, active-high reset
//   req_valid    in   1       burst request valid
//   req_ready    out  1       high only in IDLE
//   req_addr     in   ADDR_W  first byte address
//   req_len      in   LEN_W   byte count; 0 = empty burst
//   dout_valid   out  1       byte available
//   dout_ready   in   1       consumer accepts byte
//   dout_data    out  DATA_W  fetched byte
//   dout_last    out  1       marks final byte of burst (qualified by dout_valid)
//   done         out  1       one-cycle pulse at burst completion
//   rom_addr     out  ADDR_W  PROM address
//   rom_cs_n     out  1       PROM chip select, active low
//   rom_oe_n     out  1       PROM output enable, active low
//   rom_data_i   in   DATA_W  PROM data; only sampled while cs_n=oe_n=0
// BEHAVIOUR
//   Reset values: req_ready=1, dout_valid=0, dout_last=0, done=0, dout_data=0, rom_addr=0, rom_cs_n=1, rom_oe_n=1.
//   FSM IDLE -> ACCESS -> OUT -> (ACCESS | IDLE). All outputs are registered.
//   IDLE: req_ready=1. On req_valid&&req_ready, latch addr and len (req_ready=0 from the next cycle).
//     len=0: go to IDLE with done=1 the next cycle and no strobes.
//   ACCESS: rom_addr=cur_addr, rom_cs_n=0, rom_oe_n=0, held for WAIT_CYC+1 cycles.
//     On the final cycle, rom_data_i is registered into dout_data.
//   OUT: dout_valid=1, cs_n=oe_n=1, dout_last=(remaining==1). dout_data, dout_last and rom_addr are stable until accepted.
//     On dout_ready: if last, go to IDLE and pulse done; else cur_addr+1 (mod 2**ADDR_W), remaining-1, go to ACCESS.
//   Latency: accept cycle T -> first dout_valid at T+WAIT_CYC+2. Next byte at handshake cycle + WAIT_CYC+2.
//   Throughput: one byte per WAIT_CYC+2 cycles at full ready.
//   Backpressure: OUT holds indefinitely with strobes deasserted; the PROM is never strobed while a byte is pending.
//   Wrap: address 2**ADDR_W-1 increments to 0 without error.
//   req_valid outside IDLE is ignored, with no side effects.
//   rst mid-burst: next cycle returns to reset values, drops the burst and emits no done pulse.
// CONFIGURATION
//   PROM_CKSUM_EN defined:
//     adds ports cksum (out, DATA_W) and cksum_valid (out, 1).
//     cksum is the modulo-2**DATA_W sum of all bytes of the burst; cleared on request accept.
//     cksum_valid pulses together with done. A len=0 burst gives cksum=0.
//   PROM_CKSUM_EN undefined: ports and logic are absent; all other behaviour is identical.
// STRUCTURE
//   Package prom_rd_pkg: state encoding (IDLE/ACCESS/OUT) and default width constants.
//   One sub-module, prom_wait_cnt: loads WAIT_CYC on ACCESS entry and flags the final access cycle.
//   The top module holds the FSM, address/length counters, output registers and the optional checksum.
// TESTING
//   1 addr=0x0010 len=1, WAIT_CYC=3, ready=1 -> cs_n/oe_n low 4 cycles;
//     dout_valid at T+5 with data=mem[0x10], last=1; done next cycle.
//   2 addr=0x7FFE len=3 -> rom_addr 7FFE,7FFF,0000 in order; last only on the third byte.
//   3 len=4, dout_ready low for 6 cycles on byte 2 -> dout_data held;
//     cs_n=oe_n=1 throughout the stall; no byte lost or duplicated.
//   4 len=0 -> no strobes, no dout_valid, done pulse 1 cycle after accept;
//     req_valid asserted during a burst -> ignored.
//   5 rst asserted during ACCESS of byte 2 of 5 -> next cycle all outputs at reset values,
//     no done; a new request then completes normally.
//   6 PROM_CKSUM_EN defined, bytes 0xF0,0x20,0x05 -> cksum=0x15 with cksum_valid aligned to done.

Source files
------------

// File: rtl/prom_rd_pkg.sv
// Shared constants for the 27256-style PROM burst reader: default widths and FSM state encoding.
package prom_rd_pkg;

  localparam int ADDR_W_DEF   = 15;
  localparam int DATA_W_DEF   = 8;
  localparam int LEN_W_DEF    = 16;
  localparam int WAIT_CYC_DEF = 3;
  localparam int WAIT_W       = 4;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_OUT    = 2'd2;

endpackage

// File: rtl/prom_burst_reader_if.sv
// Request, byte-stream and PROM pin bundle; master is the reader, slave is its environment.
interface prom_burst_reader_if #(
  parameter int ADDR_W = 15,
  parameter int DATA_W = 8,
  parameter int LEN_W  = 16
);

  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic [LEN_W-1:0]  req_len;
  logic              dout_valid;
  logic              dout_ready;
  logic [DATA_W-1:0] dout_data;
  logic              dout_last;
  logic              done;
  logic [ADDR_W-1:0] rom_addr;
  logic              rom_cs_n;
  logic              rom_oe_n;
  logic [DATA_W-1:0] rom_data_i;

  modport master (
    input  req_valid, req_addr, req_len, dout_ready, rom_data_i,
    output req_ready, dout_valid, dout_data, dout_last, done,
           rom_addr, rom_cs_n, rom_oe_n
  );

  modport slave (
    output req_valid, req_addr, req_len, dout_ready, rom_data_i,
    input  req_ready, dout_valid, dout_data, dout_last, done,
           rom_addr, rom_cs_n, rom_oe_n
  );

endinterface

// File: rtl/prom_wait_cnt.sv
// Access wait-state counter: reloads WAIT_CYC when an access starts and flags the final access cycle.
module prom_wait_cnt
  import prom_rd_pkg::*;
#(
  parameter int WAIT_CYC = WAIT_CYC_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic load_i,
  input  logic en_i,
  output logic last_o
);

  logic [WAIT_W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= WAIT_W'(WAIT_CYC);
    end else if (en_i && (cnt_q != '0)) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign last_o = (cnt_q == '0);

endmodule

// File: rtl/prom_burst_reader.sv
// Burst reader for a 32Kx8 PROM streaming bytes over valid/ready.
// Optional burst checksum outputs are enabled by defining PROM_CKSUM_EN.
module prom_burst_reader
  import prom_rd_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int DATA_W   = DATA_W_DEF,
  parameter int LEN_W    = LEN_W_DEF,
  parameter int WAIT_CYC = WAIT_CYC_DEF
) (
  input logic clk,
  input logic rst,
  prom_burst_reader_if.master bus
`ifdef PROM_CKSUM_EN
  ,
  output logic [DATA_W-1:0] cksum,
  output logic              cksum_valid
`endif
);

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LEN_W-1:0]  remain_q, remain_d;
  logic              req_ready_q, req_ready_d;
  logic              dout_valid_q, dout_valid_d;
  logic [DATA_W-1:0] dout_data_q, dout_data_d;
  logic              dout_last_q, dout_last_d;
  logic              done_q, done_d;
  logic              strobe_n_q, strobe_n_d;

  logic accept;
  logic capture;
  logic wait_load;
  logic wait_last;

  assign accept  = (state_q == ST_IDLE) && bus.req_valid && req_ready_q;
  assign capture = (state_q == ST_ACCESS) && wait_last;

  prom_wait_cnt #(.WAIT_CYC(WAIT_CYC)) u_wait (
    .clk    (clk),
    .rst    (rst),
    .load_i (wait_load),
    .en_i   (state_q == ST_ACCESS),
    .last_o (wait_last)
  );

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    remain_d     = remain_q;
    req_ready_d  = req_ready_q;
    dout_valid_d = dout_valid_q;
    dout_data_d  = dout_data_q;
    dout_last_d  = dout_last_q;
    done_d       = 1'b0;
    strobe_n_d   = strobe_n_q;
    wait_load    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          dout_last_d = 1'b0;
          if (bus.req_len == '0) begin
            done_d = 1'b1;
          end else begin
            addr_d      = bus.req_addr;
            remain_d    = bus.req_len;
            req_ready_d = 1'b0;
            strobe_n_d  = 1'b0;
            wait_load   = 1'b1;
            state_d     = ST_ACCESS;
          end
        end
      end

      ST_ACCESS: begin
        if (capture) begin
          dout_data_d  = bus.rom_data_i;
          dout_valid_d = 1'b1;
          dout_last_d  = (remain_q == LEN_W'(1));
          strobe_n_d   = 1'b1;
          state_d      = ST_OUT;
        end
      end

      ST_OUT: begin
        // Strobes stay off here so the PROM is idle while a byte waits for the consumer.
        if (bus.dout_ready) begin
          dout_valid_d = 1'b0;
          if (dout_last_q) begin
            dout_last_d = 1'b0;
            done_d      = 1'b1;
            req_ready_d = 1'b1;
            state_d     = ST_IDLE;
          end else begin
            addr_d     = addr_q + 1'b1;
            remain_d   = remain_q - 1'b1;
            strobe_n_d = 1'b0;
            wait_load  = 1'b1;
            state_d    = ST_ACCESS;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      addr_q       <= '0;
      remain_q     <= '0;
      req_ready_q  <= 1'b1;
      dout_valid_q <= 1'b0;
      dout_data_q  <= '0;
      dout_last_q  <= 1'b0;
      done_q       <= 1'b0;
      strobe_n_q   <= 1'b1;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      remain_q     <= remain_d;
      req_ready_q  <= req_ready_d;
      dout_valid_q <= dout_valid_d;
      dout_data_q  <= dout_data_d;
      dout_last_q  <= dout_last_d;
      done_q       <= done_d;
      strobe_n_q   <= strobe_n_d;
    end
  end

  assign bus.req_ready  = req_ready_q;
  assign bus.dout_valid = dout_valid_q;
  assign bus.dout_data  = dout_data_q;
  assign bus.dout_last  = dout_last_q;
  assign bus.done       = done_q;
  assign bus.rom_addr   = addr_q;
  assign bus.rom_cs_n   = strobe_n_q;
  assign bus.rom_oe_n   = strobe_n_q;

`ifdef PROM_CKSUM_EN
  logic [DATA_W-1:0] cksum_q;
  logic              cksum_valid_q;

  // Sum is cleared on accept so an empty burst reports zero alongside its done pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      cksum_q       <= '0;
      cksum_valid_q <= 1'b0;
    end else begin
      cksum_valid_q <= done_d;
      if (accept) begin
        cksum_q <= '0;
      end else if (capture) begin
        cksum_q <= cksum_q + bus.rom_data_i;
      end
    end
  end

  assign cksum       = cksum_q;
  assign cksum_valid = cksum_valid_q;
`endif

endmodule
